// File: rtl/fp_div_seq.sv
// Sequential floating-point divider q = a / b using a radix-2 restoring mantissa
// divider with valid/ready handshakes. Optional macro FP_DIV_EARLY_OUT_EN enables early-out for special operands.
module fp_div_seq #(
    parameter int E_WIDTH = 5,
    parameter int M_WIDTH = 10,
    parameter int I_WIDTH = M_WIDTH + E_WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [I_WIDTH-1:0] a,
    input  logic [I_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [I_WIDTH-1:0] q
);

    localparam int Q_W   = M_WIDTH + 3;
    localparam int R_W   = M_WIDTH + 3;
    localparam int X_W   = E_WIDTH + 2;
    localparam int CNT_W = $clog2(Q_W + 1);
    localparam logic signed [X_W-1:0] BIAS = X_W'((1 << (E_WIDTH - 1)) - 1);
    localparam logic [E_WIDTH-1:0] EXP_MAX = '1;
    localparam logic [I_WIDTH-1:0] NAN_WORD = {1'b0, EXP_MAX, 1'b1, {(M_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM_ROUND,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [I_WIDTH-1:0]     a_reg;
    logic [I_WIDTH-1:0]     b_reg;
    logic                   sign_reg;
    logic signed [X_W-1:0]  exp_reg;
    logic [R_W-1:0]         rem_reg;
    logic [M_WIDTH:0]       div_reg;
    logic [Q_W-1:0]         quo_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   special_reg;
    logic [I_WIDTH-1:0]     special_q_reg;
    logic                   in_ready_reg;
    logic                   out_valid_reg;
    logic [I_WIDTH-1:0]     q_reg;

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign q         = q_reg;

    // Operand field decode
    logic                   sign_a;
    logic                   sign_b;
    logic [E_WIDTH-1:0]     exp_a;
    logic [E_WIDTH-1:0]     exp_b;
    logic [M_WIDTH-1:0]     man_a;
    logic [M_WIDTH-1:0]     man_b;
    logic                   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;

    assign sign_a = a_reg[I_WIDTH-1];
    assign sign_b = b_reg[I_WIDTH-1];
    assign exp_a  = a_reg[I_WIDTH-2 -: E_WIDTH];
    assign exp_b  = b_reg[I_WIDTH-2 -: E_WIDTH];
    assign man_a  = a_reg[M_WIDTH-1:0];
    assign man_b  = b_reg[M_WIDTH-1:0];
    assign nan_a  = (exp_a == EXP_MAX) && (man_a != '0);
    assign nan_b  = (exp_b == EXP_MAX) && (man_b != '0);
    assign inf_a  = (exp_a == EXP_MAX) && (man_a == '0);
    assign inf_b  = (exp_b == EXP_MAX) && (man_b == '0);
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);

    logic                   special_hit_next;
    logic [I_WIDTH-1:0]     special_q_next;
    logic                   sign_next;

    assign sign_next = sign_a ^ sign_b;

    always_comb begin
        special_hit_next = 1'b1;
        special_q_next   = NAN_WORD;
        if (nan_a || nan_b || (inf_a && inf_b) || (zero_a && zero_b)) begin
            special_q_next = NAN_WORD;
        end else if (inf_a || zero_b) begin
            special_q_next = {sign_next, EXP_MAX, {M_WIDTH{1'b0}}};
        end else if (inf_b || zero_a) begin
            special_q_next = {sign_next, {(I_WIDTH-1){1'b0}}};
        end else begin
            special_hit_next = 1'b0;
        end
    end

    logic signed [X_W-1:0]  exp_unpack_next;
    assign exp_unpack_next = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;

    // Restoring division step
    logic                   rem_ge_next;
    logic [R_W-1:0]         rem_sub_next;
    logic [R_W-1:0]         rem_next;

    assign rem_ge_next  = rem_reg >= {2'b00, div_reg};
    assign rem_sub_next = rem_ge_next ? (rem_reg - {2'b00, div_reg}) : rem_reg;
    assign rem_next     = {rem_sub_next[R_W-2:0], 1'b0};

    // Normalise and round to nearest even
    logic [Q_W-1:0]         quo_norm_next;
    logic signed [X_W-1:0]  exp_norm_next;
    logic [M_WIDTH:0]       sig_next;
    logic                   guard_next;
    logic                   sticky_next;
    logic                   inc_next;
    logic [M_WIDTH+1:0]     sig_round_next;
    logic signed [X_W-1:0]  exp_round_next;
    logic [M_WIDTH-1:0]     frac_next;
    logic [I_WIDTH-1:0]     result_next;

    always_comb begin
        if (quo_reg[Q_W-1]) begin
            quo_norm_next = quo_reg;
            exp_norm_next = exp_reg;
        end else begin
            quo_norm_next = {quo_reg[Q_W-2:0], 1'b0};
            exp_norm_next = exp_reg - X_W'(1);
        end
        sig_next       = quo_norm_next[Q_W-1:2];
        guard_next     = quo_norm_next[1];
        // After a normalising shift bit 0 is the shifted-in zero, so r drops out.
        sticky_next    = quo_norm_next[0] | (rem_reg != '0);
        inc_next       = guard_next & (sig_next[0] | sticky_next);
        sig_round_next = {1'b0, sig_next} + {{(M_WIDTH+1){1'b0}}, inc_next};
        if (sig_round_next[M_WIDTH+1]) begin
            frac_next      = '0;
            exp_round_next = exp_norm_next + X_W'(1);
        end else begin
            frac_next      = sig_round_next[M_WIDTH-1:0];
            exp_round_next = exp_norm_next;
        end
        if (exp_round_next >= $signed({2'b00, EXP_MAX})) begin
            result_next = {sign_reg, EXP_MAX, {M_WIDTH{1'b0}}};
        end else if (exp_round_next <= $signed(X_W'(0))) begin
            result_next = {sign_reg, {(I_WIDTH-1){1'b0}}};
        end else begin
            result_next = {sign_reg, exp_round_next[E_WIDTH-1:0], frac_next};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            rem_reg       <= '0;
            div_reg       <= '0;
            quo_reg       <= '0;
            cnt_reg       <= '0;
            special_reg   <= 1'b0;
            special_q_reg <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            q_reg         <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        in_ready_reg <= 1'b0;
                        state_reg    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_reg      <= sign_next;
                    exp_reg       <= exp_unpack_next;
                    rem_reg       <= {2'b00, 1'b1, man_a};
                    div_reg       <= {1'b1, man_b};
                    quo_reg       <= '0;
                    cnt_reg       <= CNT_W'(Q_W);
                    special_reg   <= special_hit_next;
                    special_q_reg <= special_q_next;
`ifdef FP_DIV_EARLY_OUT_EN
                    // Specials skip the divide loop; NORM_ROUND publishes the override.
                    state_reg     <= special_hit_next ? NORM_ROUND : DIVIDE;
`else
                    state_reg     <= DIVIDE;
`endif
                end
                DIVIDE: begin
                    quo_reg <= {quo_reg[Q_W-2:0], rem_ge_next};
                    rem_reg <= rem_next;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= NORM_ROUND;
                    end
                end
                NORM_ROUND: begin
                    q_reg         <= special_reg ? special_q_reg : result_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
